// File: rtl/bk_sector_ctrl.sv
// Backup-RAM sector transfer sequencer between on-chip NVRAM and the HPS save image.
// Handles runtime sector count, dirty tracking, autosave and ack timeout.
module bk_sector_ctrl #(
   parameter int unsigned SECTOR_BITS = 6,
   parameter logic [23:0] TIMEOUT     = 24'd0
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   bk_ena,
   input  logic                   load_req,
   input  logic                   save_req,
   input  logic                   autoload,
   input  logic                   autosave_req,
   input  logic                   img_nz,
   input  logic [SECTOR_BITS-1:0] last_sec,
   input  logic                   nvram_we,
   input  logic                   sd_ack,
   output logic [31:0]            sd_lba,
   output logic                   sd_rd,
   output logic                   sd_wr,
   output logic                   bk_loading,
   output logic                   bk_state,
   output logic                   dirty,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned CNT_W = 24;

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   state_t                 state, state_n;
   logic                   old_load, old_save, old_ack;
   logic [SECTOR_BITS-1:0] lba_q, lba_n, last_q, last_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic                   rd_n, wr_n, loading_n, busy_n, dirty_n, done_n, err_n;
   logic                   start_load, start_save, clr_dirty;
   logic                   ack_rise, ack_fall;

   assign ack_rise = sd_ack & ~old_ack;
   assign ack_fall = ~sd_ack & old_ack;
   assign sd_lba   = 32'(lba_q);

   // State and output registers; request edge registers track inputs even while busy
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         old_load   <= 1'b0;
         old_save   <= 1'b0;
         old_ack    <= 1'b0;
         lba_q      <= '0;
         last_q     <= '0;
         cnt_q      <= '0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         bk_loading <= 1'b0;
         bk_state   <= 1'b0;
         dirty      <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         old_load   <= load_req & bk_ena;
         old_save   <= save_req & bk_ena;
         old_ack    <= sd_ack;
         lba_q      <= lba_n;
         last_q     <= last_n;
         cnt_q      <= cnt_n;
         sd_rd      <= rd_n;
         sd_wr      <= wr_n;
         bk_loading <= loading_n;
         bk_state   <= busy_n;
         dirty      <= dirty_n;
         done       <= done_n;
         err        <= err_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n    = state;
      lba_n      = lba_q;
      last_n     = last_q;
      cnt_n      = cnt_q;
      rd_n       = sd_rd;
      wr_n       = sd_wr;
      loading_n  = bk_loading;
      busy_n     = bk_state;
      done_n     = 1'b0;
      err_n      = 1'b0;
      clr_dirty  = 1'b0;
      start_load = (load_req & bk_ena & ~old_load) | (autoload & img_nz & bk_ena);
      start_save = (save_req & bk_ena & ~old_save) | (autosave_req & dirty & bk_ena);

      unique case (state)
         IDLE: begin
            if (start_load | start_save) begin
               state_n   = REQ;
               busy_n    = 1'b1;
               loading_n = start_load;
               rd_n      = start_load;
               wr_n      = ~start_load;
               lba_n     = '0;
               last_n    = last_sec;
               cnt_n     = '0;
            end
         end
         REQ: begin
            if (ack_rise) begin
               rd_n    = 1'b0;
               wr_n    = 1'b0;
               state_n = XFER;
            end else if (TIMEOUT != 24'd0) begin
               cnt_n = cnt_q + CNT_W'(1);
               if (cnt_n == TIMEOUT) begin
                  rd_n      = 1'b0;
                  wr_n      = 1'b0;
                  busy_n    = 1'b0;
                  loading_n = 1'b0;
                  err_n     = 1'b1;
                  state_n   = IDLE;
               end
            end
         end
         XFER: begin
            if (ack_fall) begin
               if (lba_q == last_q) begin
                  busy_n    = 1'b0;
                  loading_n = 1'b0;
                  done_n    = 1'b1;
                  clr_dirty = 1'b1;
                  state_n   = IDLE;
               end else begin
                  lba_n   = lba_q + SECTOR_BITS'(1);
                  rd_n    = bk_loading;
                  wr_n    = ~bk_loading;
                  cnt_n   = '0;
                  state_n = REQ;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // A core write in the same cycle as completion keeps the image dirty
      dirty_n = (nvram_we & ~bk_loading) ? 1'b1 : (clr_dirty ? 1'b0 : dirty);
   end

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Bench for bk_sector_ctrl: constant start-decision table, directed sequences,
// and randomized traffic checked every cycle against a transaction-level model.
module tb_bk_sector_ctrl;

   localparam int TMO = 16;

   logic        clk_sys = 1'b0;
   logic        reset, bk_ena, load_req, save_req, autoload, autosave_req, img_nz;
   logic [5:0]  last_sec;
   logic        nvram_we, sd_ack;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, bk_loading, bk_state, dirty, done, err;

   bk_sector_ctrl #(.SECTOR_BITS(6), .TIMEOUT(24'd16)) dut (
      .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .load_req(load_req),
      .save_req(save_req), .autoload(autoload), .autosave_req(autosave_req),
      .img_nz(img_nz), .last_sec(last_sec), .nvram_we(nvram_we), .sd_ack(sd_ack),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_loading(bk_loading),
      .bk_state(bk_state), .dirty(dirty), .done(done), .err(err)
   );

   always #5 clk_sys = ~clk_sys;

   int n_pass = 0, n_total = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   // Transaction-level reference: one job = a run of sectors, each a request then an ack pulse
   bit m_busy, m_ld, m_wt, m_rd, m_wr, m_dirty, m_done, m_err, p_ld, p_sv, p_ack;
   int m_sec, m_last, m_cnt;

   task automatic model_edge();
      bit rl, rs, au, ad, set_d, clr_d;
      if (reset) begin
         {m_busy, m_ld, m_wt, m_rd, m_wr, m_dirty, m_done, m_err, p_ld, p_sv, p_ack} = '0;
         m_sec = 0; m_last = 0; m_cnt = 0;
         return;
      end
      rl = load_req && bk_ena && !p_ld;
      rs = save_req && bk_ena && !p_sv;
      au = sd_ack && !p_ack;
      ad = !sd_ack && p_ack;
      set_d = nvram_we && !m_ld;
      clr_d = 0; m_done = 0; m_err = 0;
      if (!m_busy) begin
         if (rl || (autoload && img_nz && bk_ena) || rs || (autosave_req && m_dirty && bk_ena)) begin
            m_ld = rl || (autoload && img_nz && bk_ena);
            m_busy = 1; m_wt = 1; m_sec = 0; m_last = int'(last_sec); m_cnt = 0;
            m_rd = m_ld; m_wr = !m_ld;
         end
      end else if (m_wt) begin
         if (au) begin
            m_wt = 0; m_rd = 0; m_wr = 0;
         end else begin
            m_cnt++;
            if (m_cnt == TMO) begin
               m_busy = 0; m_ld = 0; m_rd = 0; m_wr = 0; m_err = 1;
            end
         end
      end else if (ad) begin
         if (m_sec == m_last) begin
            m_busy = 0; m_ld = 0; m_done = 1; clr_d = 1;
         end else begin
            m_sec++; m_wt = 1; m_cnt = 0; m_rd = m_ld; m_wr = !m_ld;
         end
      end
      if (set_d) m_dirty = 1;
      else if (clr_d) m_dirty = 0;
      p_ld = load_req && bk_ena;
      p_sv = save_req && bk_ena;
      p_ack = sd_ack;
   endtask

   // hps_io-like ack responder and observation statistics
   bit resp_en = 0, resp_rand = 0;
   int resp_delay = 5, resp_hi = 4, r_cnt = 0, h_cnt = 0;
   int cyc = 0, n_rd, n_wr, n_done, n_err, t_rd, t_err;
   bit prev_rd, prev_wr;
   int lba_hist[$];

   task automatic clr_stats();
      n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; t_rd = -1; t_err = -1;
      lba_hist.delete();
   endtask

   task automatic step();
      if (resp_en) begin
         if (!sd_ack) begin
            if (sd_rd || sd_wr) begin
               r_cnt++;
               if (r_cnt >= resp_delay) begin sd_ack = 1; h_cnt = 0; r_cnt = 0; end
            end else r_cnt = 0;
         end else begin
            h_cnt++;
            if (h_cnt >= resp_hi) begin
               sd_ack = 0;
               if (resp_rand) begin
                  resp_delay = $urandom_range(1, 20);
                  resp_hi = $urandom_range(1, 6);
               end
            end
         end
      end
      @(posedge clk_sys);
      #1;
      cyc++;
      model_edge();
      check("cycle", 64'({sd_lba, sd_rd, sd_wr, bk_loading, bk_state, dirty, done, err}),
            64'({32'(m_sec), m_rd, m_wr, m_ld, m_busy, m_dirty, m_done, m_err}));
      if (sd_rd && !prev_rd) begin n_rd++; lba_hist.push_back(int'(sd_lba)); if (t_rd < 0) t_rd = cyc; end
      if (sd_wr && !prev_wr) begin n_wr++; lba_hist.push_back(int'(sd_lba)); end
      if (done) n_done++;
      if (err) begin n_err++; if (t_err < 0) t_err = cyc; end
      prev_rd = sd_rd;
      prev_wr = sd_wr;
   endtask

   task automatic clear_inputs();
      bk_ena = 0; load_req = 0; save_req = 0; autoload = 0; autosave_req = 0;
      img_nz = 0; nvram_we = 0; last_sec = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (bk_state && n < max) begin step(); n++; end
      check({name, "_idle"}, 64'(bk_state), 64'd0);
   endtask

   typedef struct {
      bit       dp, ena, ld, sv, al, nz, as;
      bit [3:0] exp;   // {bk_state, bk_loading, sd_rd, sd_wr}
   } vec_t;
   vec_t tbl[12];

   initial begin
      tbl[0]  = '{0, 1, 1, 0, 0, 0, 0, 4'b1110};  // load_req
      tbl[1]  = '{0, 1, 0, 1, 0, 0, 0, 4'b1001};  // save_req
      tbl[2]  = '{0, 1, 1, 1, 0, 0, 0, 4'b1110};  // load beats save
      tbl[3]  = '{0, 0, 1, 1, 1, 1, 0, 4'b0000};  // bk_ena low gates all
      tbl[4]  = '{0, 1, 0, 0, 1, 0, 0, 4'b0000};  // autoload, empty image
      tbl[5]  = '{0, 1, 0, 0, 1, 1, 0, 4'b1110};  // autoload
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 1, 4'b0000};  // autosave, clean
      tbl[7]  = '{1, 1, 0, 0, 0, 0, 1, 4'b1001};  // autosave, dirty
      tbl[8]  = '{1, 0, 0, 0, 0, 0, 1, 4'b0000};  // autosave, disabled
      tbl[9]  = '{1, 1, 0, 1, 1, 1, 0, 4'b1110};  // autoload beats save_req
      tbl[10] = '{1, 1, 0, 1, 0, 0, 1, 4'b1001};  // save_req with autosave
      tbl[11] = '{0, 0, 0, 0, 1, 1, 0, 4'b0000};  // autoload, disabled

      clear_inputs();
      sd_ack = 0; reset = 1; prev_rd = 0; prev_wr = 0;
      clr_stats();
      do_reset();
      check("reset", 64'({sd_lba, sd_rd, sd_wr, bk_loading, bk_state, dirty, done, err}), 64'd0);

      foreach (tbl[i]) begin
         do_reset();
         if (tbl[i].dp) begin nvram_we = 1; step(); nvram_we = 0; end
         bk_ena = tbl[i].ena; load_req = tbl[i].ld; save_req = tbl[i].sv;
         autoload = tbl[i].al; img_nz = tbl[i].nz; autosave_req = tbl[i].as;
         step();
         check($sformatf("tbl%0d", i), 64'({bk_state, bk_loading, sd_rd, sd_wr}), 64'(tbl[i].exp));
         clear_inputs();
      end

      // Four-sector load with a well-behaved responder
      do_reset();
      resp_en = 1; resp_delay = 5; resp_hi = 4;
      bk_ena = 1; last_sec = 6'd3; clr_stats();
      load_req = 1; step(); load_req = 0;
      wait_idle("load4", 500);
      check("load4_nrd", 64'(n_rd), 64'd4);
      check("load4_nwr", 64'(n_wr), 64'd0);
      foreach (lba_hist[i]) check($sformatf("load4_lba%0d", i), 64'(lba_hist[i]), 64'(i));
      check("load4_done", 64'(n_done), 64'd1);
      check("load4_dirty", 64'(dirty), 64'd0);

      // Dirty then autosave; a second autosave on a clean image does nothing
      nvram_we = 1; step(); nvram_we = 0; step();
      check("dirty_set", 64'(dirty), 64'd1);
      clr_stats();
      autosave_req = 1; step(); autosave_req = 0;
      wait_idle("asave", 500);
      check("asave_nwr", 64'(n_wr), 64'd4);
      check("asave_nrd", 64'(n_rd), 64'd0);
      check("asave_dirty", 64'(dirty), 64'd0);
      clr_stats();
      autosave_req = 1; step(); autosave_req = 0;
      repeat (10) step();
      check("asave2_nwr", 64'(n_wr), 64'd0);

      // Simultaneous load/save: load wins, held save_req never fires later
      clr_stats();
      load_req = 1; save_req = 1; step();
      check("both_loading", 64'(bk_loading), 64'd1);
      load_req = 0;
      wait_idle("both", 500);
      repeat (10) step();
      check("both_nwr", 64'(n_wr), 64'd0);
      check("both_nrd", 64'(n_rd), 64'd4);
      save_req = 0;

      // Ack timeout, then a late ack that must be ignored
      do_reset();
      resp_en = 0; sd_ack = 0; bk_ena = 1; last_sec = 6'd3; clr_stats();
      load_req = 1; step(); load_req = 0;
      begin
         int n = 0;
         while (!err && n < 40) begin step(); n++; end
      end
      check("tmo_delay", 64'(t_err - t_rd), 64'(TMO));
      check("tmo_busy", 64'({bk_state, sd_rd}), 64'd0);
      sd_ack = 1; repeat (3) step(); sd_ack = 0; repeat (3) step();
      check("tmo_late", 64'({n_rd, bk_state}), 64'({32'd1, 1'b0}));

      // Reset during the transfer of sector 2, then restart from sector 0
      do_reset();
      resp_en = 1; resp_delay = 5; resp_hi = 4; bk_ena = 1; last_sec = 6'd5;
      load_req = 1;
      begin
         int n = 0;
         step();
         while (!(sd_lba == 32'd2 && sd_ack && !sd_rd) && n < 200) begin step(); n++; end
         check("rst_reach", 64'(n < 200), 64'd1);
      end
      reset = 1; step(); reset = 0;
      check("rst_outs", 64'({sd_lba, sd_rd, sd_wr, bk_loading, bk_state, dirty, done, err}), 64'd0);
      step();
      check("rst_restart", 64'({sd_lba, sd_rd}), 64'({32'd0, 1'b1}));
      load_req = 0;
      wait_idle("rst", 500);

      // Full 64-sector autoload
      clr_stats();
      resp_delay = 2; resp_hi = 2; last_sec = 6'd63; img_nz = 1;
      autoload = 1; step(); autoload = 0;
      wait_idle("al64", 3000);
      check("al64_nrd", 64'(n_rd), 64'd64);
      check("al64_done", 64'(n_done), 64'd1);

      // Randomized traffic against the model
      clear_inputs();
      do_reset();
      resp_rand = 1;
      repeat (3000) begin
         reset = ($urandom_range(0, 199) == 0);
         bk_ena = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) == 0) load_req = ~load_req;
         if ($urandom_range(0, 9) == 0) save_req = ~save_req;
         autoload = ($urandom_range(0, 29) == 0);
         autosave_req = ($urandom_range(0, 14) == 0);
         img_nz = ($urandom_range(0, 4) != 0);
         nvram_we = ($urandom_range(0, 4) == 0);
         last_sec = 6'($urandom_range(0, 3));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
